// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
// Request/response bundle between one data-memory master and dmem_arbiter.
//
// Signals:
//   req    master -> arbiter  request, held high until ack
//   we     master -> arbiter  1 = write, 0 = read (stable while req pending)
//   addr   master -> arbiter  byte address (stable while req pending)
//   wdata  master -> arbiter  write data (stable while req pending)
//   ack    arbiter -> master  one-cycle completion pulse
//   rdata  arbiter -> master  read data, valid with ack for a read
//   err    arbiter -> master  range/alignment error, valid with ack
//
// Modports: master (requester side), slave (arbiter side).
// ---------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic [DW-1:0] rdata;
    logic          err;

    modport master (output req, we, addr, wdata, input ack, rdata, err);
    modport slave  (input req, we, addr, wdata, output ack, rdata, err);
endinterface

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Two-master round-robin arbiter and sequencer in front of a single-port data
// memory (combinational read, synchronous write, word index = addr[AW-1:2]).
// Each access takes ACCESS (memory driven) then DONE (ack pulse); under
// contention the arbiter goes DONE -> ACCESS for the other port directly.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   port0      CPU load/store master (dmem_arbiter_if.slave)
//   port1      secondary master, DMA/peripheral (dmem_arbiter_if.slave)
//   mem_we_o   memory write enable
//   mem_a_o    memory byte address
//   mem_wd_o   memory write data
//   mem_rd_i   memory combinational read data
//
// Optional feature (macro DMEM_ARB_PERF_EN):
//   gnt_cnt0_o/gnt_cnt1_o    saturating count of acks per port
//   wait_cnt0_o/wait_cnt1_o  saturating count of cycles a port requests
//                            while the arbiter is busy serving the other port
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int DEPTH = 64,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave port0,
    dmem_arbiter_if.slave port1,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_a_o,
    output logic [DW-1:0] mem_wd_o,
    input  logic [DW-1:0] mem_rd_i
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [15:0]   gnt_cnt0_o,
    output logic [15:0]   gnt_cnt1_o,
    output logic [15:0]   wait_cnt0_o,
    output logic [15:0]   wait_cnt1_o
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [AW-3:0] DEPTH_W = (AW-2)'(DEPTH);

    state_t        state_q, state_d;
    logic          gsel_q, gsel_d;
    logic          prio_q, prio_d;
    logic          ack0_q, ack0_d, ack1_q, ack1_d;
    logic          err0_q, err0_d, err1_q, err1_d;
    logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic          elig0, elig1;
    logic          selWe;
    logic [AW-1:0] selAddr;
    logic [DW-1:0] selWdata;
    logic          bad;
    logic          inAccess;

    // Granted port's request fields and the memory-side drive; the memory
    // is only driven in ACCESS so a reset drops mem_we_o immediately.
    always_comb begin
        selWe    = gsel_q ? port1.we    : port0.we;
        selAddr  = gsel_q ? port1.addr  : port0.addr;
        selWdata = gsel_q ? port1.wdata : port0.wdata;
        bad      = (selAddr[1:0] != 2'b00) || (selAddr[AW-1:2] >= DEPTH_W);
        inAccess = (state_q == ACCESS);
        mem_we_o = inAccess && selWe && !bad;
        mem_a_o  = inAccess ? selAddr  : '0;
        mem_wd_o = inAccess ? selWdata : '0;
    end

    // The port being acknowledged in DONE is masked so a held-high req is
    // treated as a fresh request from the following cycle.
    always_comb begin
        elig0 = port0.req && !((state_q == DONE) && !gsel_q);
        elig1 = port1.req && !((state_q == DONE) &&  gsel_q);
    end

    // FSM next-state and registered response values.
    always_comb begin
        state_d  = state_q;
        gsel_d   = gsel_q;
        prio_d   = prio_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        err0_d   = 1'b0;
        err1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            IDLE: begin
                if (elig0 || elig1) begin
                    state_d = ACCESS;
                    gsel_d  = (elig0 && elig1) ? prio_q : elig1;
                end
            end
            ACCESS: begin
                state_d = DONE;
                prio_d  = !gsel_q;
                if (!gsel_q) begin
                    ack0_d = 1'b1;
                    err0_d = bad;
                    if (!selWe) rdata0_d = bad ? '0 : mem_rd_i;
                end else begin
                    ack1_d = 1'b1;
                    err1_d = bad;
                    if (!selWe) rdata1_d = bad ? '0 : mem_rd_i;
                end
            end
            DONE: begin
                if (gsel_q ? elig0 : elig1) begin
                    state_d = ACCESS;
                    gsel_d  = !gsel_q;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gsel_q   <= 1'b0;
            prio_q   <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            gsel_q   <= gsel_d;
            prio_q   <= prio_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign port0.ack   = ack0_q;
    assign port0.err   = err0_q;
    assign port0.rdata = rdata0_q;
    assign port1.ack   = ack1_q;
    assign port1.err   = err1_q;
    assign port1.rdata = rdata1_q;

`ifdef DMEM_ARB_PERF_EN
    logic [15:0] gntCnt0_q, gntCnt0_d, gntCnt1_q, gntCnt1_d;
    logic [15:0] waitCnt0_q, waitCnt0_d, waitCnt1_q, waitCnt1_d;
    logic        busy;

    // A port is waiting while it requests and the arbiter is busy with the
    // other port; all counters stick at all-ones.
    always_comb begin
        busy       = (state_q != IDLE);
        gntCnt0_d  = gntCnt0_q;
        gntCnt1_d  = gntCnt1_q;
        waitCnt0_d = waitCnt0_q;
        waitCnt1_d = waitCnt1_q;
        if (ack0_q && (gntCnt0_q != 16'hFFFF)) gntCnt0_d = gntCnt0_q + 16'd1;
        if (ack1_q && (gntCnt1_q != 16'hFFFF)) gntCnt1_d = gntCnt1_q + 16'd1;
        if (port0.req && busy && gsel_q && (waitCnt0_q != 16'hFFFF))
            waitCnt0_d = waitCnt0_q + 16'd1;
        if (port1.req && busy && !gsel_q && (waitCnt1_q != 16'hFFFF))
            waitCnt1_d = waitCnt1_q + 16'd1;
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gntCnt0_q  <= '0;
            gntCnt1_q  <= '0;
            waitCnt0_q <= '0;
            waitCnt1_q <= '0;
        end else begin
            gntCnt0_q  <= gntCnt0_d;
            gntCnt1_q  <= gntCnt1_d;
            waitCnt0_q <= waitCnt0_d;
            waitCnt1_q <= waitCnt1_d;
        end
    end

    assign gnt_cnt0_o  = gntCnt0_q;
    assign gnt_cnt1_o  = gntCnt1_q;
    assign wait_cnt0_o = waitCnt0_q;
    assign wait_cnt1_o = waitCnt1_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Bench for dmem_arbiter: owns the data memory, drives both masters through
// two dmem_arbiter_if instances, and keeps a word-level reference memory.
// Build with DMEM_ARB_PERF_EN defined to exercise the performance counters.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_arbiter;
    localparam int DEPTH = 64;
    localparam int AW    = 32;
    localparam int DW    = 32;

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        bit          expErr;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        reqT[2];
    logic        weT[2];
    logic [31:0] addrT[2];
    logic [31:0] wdataT[2];

    dmem_arbiter_if #(.AW(AW), .DW(DW)) if0 ();
    dmem_arbiter_if #(.AW(AW), .DW(DW)) if1 ();

    assign if0.req   = reqT[0];
    assign if0.we    = weT[0];
    assign if0.addr  = addrT[0];
    assign if0.wdata = wdataT[0];
    assign if1.req   = reqT[1];
    assign if1.we    = weT[1];
    assign if1.addr  = addrT[1];
    assign if1.wdata = wdataT[1];

    logic        memWe;
    logic [31:0] memA;
    logic [31:0] memWd;
    logic [31:0] memRd;
`ifdef DMEM_ARB_PERF_EN
    logic [15:0] gntCnt0, gntCnt1, waitCnt0, waitCnt1;
`endif

    dmem_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .port0       (if0),
        .port1       (if1),
        .mem_we_o    (memWe),
        .mem_a_o     (memA),
        .mem_wd_o    (memWd),
        .mem_rd_i    (memRd)
`ifdef DMEM_ARB_PERF_EN
        ,
        .gnt_cnt0_o  (gntCnt0),
        .gnt_cnt1_o  (gntCnt1),
        .wait_cnt0_o (waitCnt0),
        .wait_cnt1_o (waitCnt1)
`endif
    );

    int tests    = 0;
    int failures = 0;
    int cycleCnt = 0;

    logic [31:0] mem[64];
    logic [31:0] refMem[64];
    logic        memLoad = 1'b1;
    logic [31:0] lastRdata[2];
    int          lastAckPort;
    bit          pending[2];
    int          startCycle[2];

    function automatic logic [31:0] initVal(input int i);
        return (i == 5) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(i);
    endfunction

    function automatic bit isBad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:2] >= 30'd64);
    endfunction

    function automatic logic ackOf(input int p);
        return (p == 1) ? if1.ack : if0.ack;
    endfunction

    function automatic logic errOf(input int p);
        return (p == 1) ? if1.err : if0.err;
    endfunction

    function automatic logic [31:0] rdataOf(input int p);
        return (p == 1) ? if1.rdata : if0.rdata;
    endfunction

    // Single-port memory: combinational read, synchronous write.
    always @(posedge clk) begin
        if (memLoad) begin
            for (int i = 0; i < 64; i++) mem[i] <= initVal(i);
        end else if (memWe && (memA[31:2] < 30'd64)) begin
            mem[memA[7:2]] <= memWd;
        end
    end
    assign memRd = (memA[31:2] < 30'd64) ? mem[memA[7:2]] : 32'hA5A5A5A5;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // A write strobe must never reach the memory for a bad address.
    always @(negedge clk) begin
        if (memWe) checkOutput("memWeAddrLegal", 32'(isBad(memA)), 32'd0);
    end

    task automatic resetDut();
        for (int p = 0; p < 2; p++) begin
            reqT[p]      = 1'b0;
            weT[p]       = 1'b0;
            addrT[p]     = '0;
            wdataT[p]    = '0;
            lastRdata[p] = '0;
            pending[p]   = 1'b0;
        end
        lastAckPort = -1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One isolated transaction checked cycle by cycle from the IDLE cycle.
    task automatic applyStimulus(input vec_t v, input int idx);
        int p;
        p = v.port;
        @(posedge clk);
        #1;
        weT[p]    = v.we;
        addrT[p]  = v.addr;
        wdataT[p] = v.wdata;
        reqT[p]   = 1'b1;
        @(negedge clk);
        checkOutput($sformatf("vec%0d c0 ack", idx), 32'(ackOf(p)), 32'd0);
        @(negedge clk);
        checkOutput($sformatf("vec%0d c1 memA", idx), memA, v.addr);
        checkOutput($sformatf("vec%0d c1 memWe", idx), 32'(memWe), 32'(v.we && !v.expErr));
        if (v.we) checkOutput($sformatf("vec%0d c1 memWd", idx), memWd, v.wdata);
        @(negedge clk);
        checkOutput($sformatf("vec%0d c2 ack", idx), 32'(ackOf(p)), 32'd1);
        checkOutput($sformatf("vec%0d c2 err", idx), 32'(errOf(p)), 32'(v.expErr));
        checkOutput($sformatf("vec%0d c2 rdata", idx), rdataOf(p),
                    v.we ? lastRdata[p] : v.expRdata);
        reqT[p] = 1'b0;
        if (!v.we) lastRdata[p] = v.expRdata;
        if (v.we && !v.expErr) refMem[v.addr[7:2]] = v.wdata;
        @(negedge clk);
        checkOutput($sformatf("vec%0d c3 ack", idx), 32'(ackOf(p)), 32'd0);
        checkOutput($sformatf("vec%0d c3 err", idx), 32'(errOf(p)), 32'd0);
    endtask

    // Randomised master; the arbitration rule is checked from request ages.
    task automatic randomMaster(input int p, input int nTx);
        int          o;
        int          gap;
        int          sel;
        int          t;
        bit          got;
        bit          bad;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        o = 1 - p;
        @(posedge clk);
        #1;
        for (int n = 0; n < nTx; n++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            sel = $urandom_range(0, 9);
            if (sel < 7)       a = {24'b0, 6'($urandom_range(0, 63)), 2'b00};
            else if (sel == 7) a = {24'b0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
            else               a = {22'b0, 8'($urandom_range(64, 200)), 2'b00};
            wr = 1'($urandom_range(0, 1));
            d  = $urandom;
            weT[p]        = wr;
            addrT[p]      = a;
            wdataT[p]     = d;
            reqT[p]       = 1'b1;
            startCycle[p] = cycleCnt;
            pending[p]    = 1'b1;
            got = 1'b0;
            for (int w = 0; w < 12 && !got; w++) begin
                @(negedge clk);
                if (ackOf(p)) begin
                    got = 1'b1;
                    t   = cycleCnt;
                    bad = isBad(a);
                    checkOutput($sformatf("rnd p%0d err", p), 32'(errOf(p)), 32'(bad));
                    if (wr) begin
                        checkOutput($sformatf("rnd p%0d wr rdata hold", p), rdataOf(p), lastRdata[p]);
                        if (!bad) refMem[a[7:2]] = d;
                    end else begin
                        checkOutput($sformatf("rnd p%0d rdata a=%h", p, a), rdataOf(p),
                                    bad ? 32'd0 : refMem[a[7:2]]);
                        lastRdata[p] = bad ? 32'd0 : refMem[a[7:2]];
                    end
                    checkOutput($sformatf("rnd p%0d fairness", p),
                                32'((lastAckPort == p) && pending[o] && (startCycle[o] <= t - 2)),
                                32'd0);
                    lastAckPort = p;
                end
            end
            checkOutput($sformatf("rnd p%0d acked", p), 32'(got), 32'd1);
            pending[p] = 1'b0;
            @(posedge clk);
            #1;
            reqT[p] = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs[11];
        vecs[0]  = '{1'b0, 1'b0, 32'h14,  32'h0,        32'hDEADBEEF, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 32'h20,  32'h12345678, 32'h0,        1'b0};
        vecs[2]  = '{1'b0, 1'b0, 32'h20,  32'h0,        32'h12345678, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 32'h100, 32'hFFFFFFFF, 32'h0,        1'b1};
        vecs[4]  = '{1'b0, 1'b1, 32'h22,  32'hFFFFFFFF, 32'h0,        1'b1};
        vecs[5]  = '{1'b0, 1'b0, 32'h20,  32'h0,        32'h12345678, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 32'h104, 32'h0,        32'h0,        1'b1};
        vecs[7]  = '{1'b1, 1'b0, 32'hFC,  32'h0,        32'h1000003F, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 32'h03,  32'h0,        32'h0,        1'b1};
        vecs[9]  = '{1'b0, 1'b1, 32'hFC,  32'hCAFEF00D, 32'h0,        1'b0};
        vecs[10] = '{1'b1, 1'b0, 32'hFC,  32'h0,        32'hCAFEF00D, 1'b0};

        for (int i = 0; i < 64; i++) refMem[i] = initVal(i);
        resetDut();
        memLoad = 1'b0;

        // Reset values.
        @(negedge clk);
        checkOutput("reset ack0", 32'(if0.ack), 32'd0);
        checkOutput("reset ack1", 32'(if1.ack), 32'd0);
        checkOutput("reset err0", 32'(if0.err), 32'd0);
        checkOutput("reset err1", 32'(if1.err), 32'd0);
        checkOutput("reset rdata0", if0.rdata, 32'd0);
        checkOutput("reset rdata1", if1.rdata, 32'd0);
        checkOutput("reset memWe", 32'(memWe), 32'd0);
        checkOutput("reset memA", memA, 32'd0);
        checkOutput("reset memWd", memWd, 32'd0);

        // Isolated transactions.
        for (int i = 0; i < 11; i++) applyStimulus(vecs[i], i);

        // Both ports held high from reset: strict 0,1,0 alternation.
        resetDut();
        @(posedge clk);
        #1;
        weT[0] = 1'b0; addrT[0] = 32'h14; reqT[0] = 1'b1;
        weT[1] = 1'b0; addrT[1] = 32'h20; reqT[1] = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            checkOutput($sformatf("rr c%0d ack0", c), 32'(if0.ack), 32'((c == 2) || (c == 6)));
            checkOutput($sformatf("rr c%0d ack1", c), 32'(if1.ack), 32'(c == 4));
            if (c == 2) checkOutput("rr c2 rdata0", if0.rdata, refMem[5]);
            if (c == 4) checkOutput("rr c4 rdata1", if1.rdata, refMem[8]);
        end
        reqT[0] = 1'b0;
        reqT[1] = 1'b0;
        repeat (3) @(posedge clk);

        // Reset in the middle of a port 1 write.
        @(posedge clk);
        #1;
        weT[1] = 1'b1; addrT[1] = 32'h08; wdataT[1] = 32'h55AA55AA; reqT[1] = 1'b1;
        @(posedge clk);
        #2;
        checkOutput("midrst memWe before", 32'(memWe), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst memWe after", 32'(memWe), 32'd0);
        checkOutput("midrst memA after", memA, 32'd0);
        reqT[1] = 1'b0;
        weT[1]  = 1'b0;
        lastRdata[0] = '0;
        lastRdata[1] = '0;
        @(posedge clk);
        #1;
        checkOutput("midrst word2", mem[2], refMem[2]);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput($sformatf("midrst ack1 c%0d", c), 32'(if1.ack), 32'd0);
        end
        @(posedge clk);
        #1;
        weT[0] = 1'b0; addrT[0] = 32'h14; reqT[0] = 1'b1;
        weT[1] = 1'b0; addrT[1] = 32'h20; reqT[1] = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            checkOutput($sformatf("postrst c%0d ack0", c), 32'(if0.ack), 32'(c == 2));
            checkOutput($sformatf("postrst c%0d ack1", c), 32'(if1.ack), 32'(c == 4));
            if (c == 2) reqT[0] = 1'b0;
        end
        reqT[1] = 1'b0;
        repeat (3) @(posedge clk);

`ifdef DMEM_ARB_PERF_EN
        // Counters over three contended accesses; port 1 leaves after its ack.
        resetDut();
        @(negedge clk);
        checkOutput("perf reset gnt0", 32'(gntCnt0), 32'd0);
        checkOutput("perf reset wait1", 32'(waitCnt1), 32'd0);
        @(posedge clk);
        #1;
        weT[0] = 1'b0; addrT[0] = 32'h14; reqT[0] = 1'b1;
        weT[1] = 1'b0; addrT[1] = 32'h20; reqT[1] = 1'b1;
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            if (c == 4) reqT[1] = 1'b0;
            if (c == 6) reqT[0] = 1'b0;
        end
        checkOutput("perf gnt0", 32'(gntCnt0), 32'd2);
        checkOutput("perf gnt1", 32'(gntCnt1), 32'd1);
        checkOutput("perf wait1", 32'(waitCnt1), 32'd2);
        checkOutput("perf wait0", 32'(waitCnt0), 32'd2);
        repeat (3) @(posedge clk);
`endif

        // Random traffic from both masters against the reference memory.
        resetDut();
        fork
            randomMaster(0, 150);
            randomMaster(1, 150);
        join
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 64; i++)
            checkOutput($sformatf("final mem[%0d]", i), mem[i], refMem[i]);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-master arbiter and sequencer in front of the single-port data memory (combinational read, synchronous write, word-indexed by a[31:2]).
- Port 0 is the CPU load/store path; port 1 is a secondary master (DMA/peripheral).
- Grants one access at a time using round-robin, checks address range and alignment, and returns registered read data with a one-cycle ack pulse.

Parameters:
- DEPTH, 64, number of 32-bit words in the data memory; word index = addr[31:2].
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- req0  in  1  port 0 request; held high until ack0
- we0  in  1  port 0 write enable (1 = write, 0 = read); stable while req0 is pending
- addr0  in  AW  port 0 byte address; stable while req0 is pending
- wdata0  in  DW  port 0 write data; stable while req0 is pending
- ack0  out  1  one-cycle completion pulse for port 0
- rdata0  out  DW  port 0 read data; valid when ack0=1 for a read
- err0  out  1  port 0 error flag; valid with ack0
- req1, we1, addr1, wdata1, ack1, rdata1, err1  same as port 0, for port 1
- mem_we  out  1  memory write enable
- mem_a  out  AW  memory address
- mem_wd  out  DW  memory write data
- mem_rd  in  DW  memory combinational read data

Behaviour:
- Reset values: ack0/1=0, err0/1=0, rdata0/1=0, state=IDLE, prio=port 0, gsel=0. With state≠ACCESS: mem_we=0, mem_a=0, mem_wd=0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If any request is eligible: pick gsel, go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - mem_a and mem_wd are driven combinationally from the gsel port's addr/wdata.
  - mem_we = we_gsel AND NOT bad.
  - bad = (addr[1:0]≠0) OR (addr[AW-1:2] ≥ DEPTH).
  - At the clock edge: write commits; for a read, rdata_gsel <= mem_rd (for a write, rdata_gsel is unchanged); err_gsel <= bad; ack_gsel <= 1; prio <= other port; go to DONE.
  - A bad read returns rdata=0 with err=1.
- DONE:
  - ack_gsel=1 for exactly this cycle.
  - The served port's req is masked for this cycle; the requester must drop req, or keep it high to issue a new request that is considered from the next cycle.
  - If the other port's req=1: gsel <= other port, go to ACCESS directly.
  - Otherwise go to IDLE.
  - ack and err return to 0 on leaving DONE. rdata holds its value until the next read for that port.
- Arbitration:
  - Only one port eligible: grant it.
  - Both eligible: grant prio. prio toggles after every completed access, so contention alternates 0,1,0,1.
- Latency:
  - req sampled high in IDLE at edge E0.
  - ACCESS occupies cycle 1; the write commits at the end of cycle 1.
  - ack is high in cycle 2.
  - Peak throughput: one access per 2 cycles under contention (DONE→ACCESS for the other port).
- Protocol: changing we/addr/wdata while req is pending and before ack is a protocol violation. The values present during ACCESS are the ones used.
- Reset mid-operation:
  - Asserting reset forces IDLE immediately (asynchronously).
  - mem_we drops combinationally, so no write occurs at the following edge.
  - A pending ack is never issued; prio returns to port 0.
- Out-of-range or misaligned writes are suppressed (mem_we stays 0) but still acknowledged with err=1.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- Defined: adds outputs gnt_cnt0, gnt_cnt1, wait_cnt0, wait_cnt1 (16 bits each, reset to 0).
  - gnt_cntK increments on each ackK.
  - wait_cntK increments each cycle reqK=1 while port K is not the gsel port in ACCESS or DONE.
  - All counters saturate at 0xFFFF.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Memory word 5 = 0xDEADBEEF; req0 read at addr 0x14 in IDLE at cycle 0 → mem_a=0x14 in cycle 1; ack0=1, rdata0=0xDEADBEEF, err0=0 in cycle 2; ack0=0 in cycle 3.
2. req1 write, addr 0x20, wdata 0x12345678 → mem_we=1, mem_a=0x20, mem_wd=0x12345678 in cycle 1 only; ack1 in cycle 2; a following port 0 read of 0x20 returns 0x12345678.
3. req0 and req1 both raised at cycle 0 after reset and held high → ack0 in cycle 2, ack1 in cycle 4, ack0 in cycle 6 (strict alternation, no IDLE between accesses).
4. Port 0 write to 0x100 (index 64 ≥ DEPTH), then a write to 0x22 (misaligned) → mem_we stays 0 for both; ack0 with err0=1 for each; memory unchanged.
5. Port 1 write to 0x08 with reset driven low mid-cycle during ACCESS → mem_we falls immediately, word 2 unchanged, ack1 never asserted; after release, simultaneous requests grant port 0 first.
6. With DMEM_ARB_PERF_EN defined, run scenario 3 for 3 acks → gnt_cnt0=2, gnt_cnt1=1, wait_cnt1=2.
